// File: rtl/uart_pkg.sv
// Framing definitions shared by the UART transmit and receive paths.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        STOP   = 3'd3,
        PARITY = 3'd4
    } uart_state_e;

    localparam int   DATA_BITS   = 8;
    localparam logic STOP_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;

    // Even parity: the extra bit makes the total count of ones even.
    function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: pulses bit_tick on the last clock of every bit while enabled.
// A synchronous clear realigns the bit grid to the start of a new frame.
module uart_baud_tick #(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clear,
    output logic bit_tick
);

    localparam int               CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

    assign bit_tick = en && (cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a valid/ready byte interface and registered line output.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       uart_out,
    output logic       tx_busy,
    output logic       tx_done
);

    uart_state_e          state;
    logic [DATA_BITS-1:0] shift_reg;
    logic [2:0]           bit_idx;
    logic                 bit_tick;
    logic                 accept;
`ifdef UART_TX_PARITY_EN
    logic                 parity_bit;
`endif

    assign accept = tx_valid && tx_ready;

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud_tick (
        .clk      (clk),
        .rst      (rst),
        .en       (tx_busy),
        .clear    (accept),
        .bit_tick (bit_tick)
    );

    // NOTE: every register here uses non-blocking assignment so all of them
    // update from the same pre-edge values; blocking would create ordering races.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            // NOTE: these are plain flops, so resetting them is free; a RAM
            // array would not be reset this way.
            shift_reg <= '0;
            bit_idx   <= '0;
            uart_out  <= STOP_LEVEL;
            tx_ready  <= 1'b1;
            tx_busy   <= 1'b0;
            tx_done   <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_bit <= 1'b0;
`endif
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        shift_reg <= tx_data;
                        bit_idx   <= '0;
                        uart_out  <= START_LEVEL;
                        tx_ready  <= 1'b0;
                        tx_busy   <= 1'b1;
                        state     <= START;
`ifdef UART_TX_PARITY_EN
                        parity_bit <= even_parity(tx_data);
`endif
                    end
                end

                START: begin
                    if (bit_tick) begin
                        uart_out <= shift_reg[0];
                        state    <= DATA;
                    end
                end

                DATA: begin
                    if (bit_tick) begin
                        shift_reg <= shift_reg >> 1;
                        bit_idx   <= bit_idx + 3'd1;
                        if (bit_idx == 3'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                            uart_out <= parity_bit;
                            state    <= PARITY;
`else
                            uart_out <= STOP_LEVEL;
                            state    <= STOP;
`endif
                        end else begin
                            // Next bit is what will sit in bit 0 after this shift.
                            uart_out <= shift_reg[1];
                        end
                    end
                end

`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (bit_tick) begin
                        uart_out <= STOP_LEVEL;
                        state    <= STOP;
                    end
                end
`endif

                STOP: begin
                    if (bit_tick) begin
                        tx_done  <= 1'b1;
                        tx_ready <= 1'b1;
                        tx_busy  <= 1'b0;
                        state    <= IDLE;
                    end
                end

                default: begin
                    uart_out <= STOP_LEVEL;
                    tx_ready <= 1'b1;
                    tx_busy  <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule
